// File: rtl/serial_sched_pkg.sv
// Shared definitions for the serial shift scheduler.
//   sched_state_t : FSM state encoding (IDLE / SHIFT / GAP)
//   idx_width()   : bits needed for a requester index (never less than 1)
//   count_width() : bits needed for a counter that runs from 0 to n-1 (never less than 1)
package serial_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_t;

  // Narrowest legal frame and requester count
  localparam int SCHED_MIN_WIDTH = 2;
  localparam int SCHED_MIN_NREQ  = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter.
//   req        : per-requester request vector
//   last_grant : index granted most recently; search starts one above it
//   enable     : when low, no grant is issued
//   grant      : one-hot grant (all zero when nothing is requested or disabled)
//   grant_idx  : encoded index of the granted requester (0 when no grant)
module rr_arbiter
  import serial_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]              req,
  input  logic [idx_width(NREQ)-1:0]   last_grant,
  input  logic                         enable,
  output logic [NREQ-1:0]              grant,
  output logic [idx_width(NREQ)-1:0]   grant_idx
);

  localparam int IDX_W = idx_width(NREQ);

  logic found;
  int   cand;

  // Walk the requesters in priority order last_grant+1, +2, ... wrapping
  // around; the requester just served is examined last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    if (enable) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = (int'(last_grant) + k) % NREQ;
        if (!found && req[IDX_W'(cand)]) begin
          found                  = 1'b1;
          grant[IDX_W'(cand)]    = 1'b1;
          grant_idx              = IDX_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/serial_shift_scheduler.sv
// Time-shares one serial shift-out path between NREQ parallel-word requesters.
// A round-robin arbiter picks one requester per frame; its word is loaded into
// a shift register and sent MSB-first, followed by GAP_CYCLES idle cycles.
//   clk         : rising-edge clock
//   reset       : asynchronous, active-low; aborts any frame in progress
//   req_valid   : per-requester word available
//   req_data    : requester i word at bits [i*WIDTH +: WIDTH]
//   req_ready   : one-hot grant, combinational, only while idle
//   serial_out  : current serial bit (0 outside a frame)
//   shift_en    : high on every cycle carrying a valid serial bit
//   frame_start : high on the first bit of a frame
//   owner       : index of the requester currently shifting
//   busy        : high while shifting or in the inter-frame gap
module serial_shift_scheduler
  import serial_sched_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*WIDTH-1:0]       req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic                        serial_out,
  output logic                        shift_en,
  output logic                        frame_start,
  output logic [idx_width(NREQ)-1:0]  owner,
  output logic                        busy
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int CNT_W = count_width(WIDTH);
  localparam int GAP_W = count_width((GAP_CYCLES > 0) ? GAP_CYCLES : 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_t        state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;

  logic [NREQ-1:0]     grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                arb_en;
  logic                handshake;
  logic [WIDTH-1:0]    sel_word;

  // Reset is folded into the enable so req_ready reads all-zero while reset
  // is held low, even though the FSM already sits in IDLE.
  assign arb_en = (state_q == ST_IDLE) && reset;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .enable     (arb_en),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = grant;
  // The arbiter only grants a requesting input, so any grant is a transfer.
  assign handshake = |grant;

  // One-hot mux of the granted word.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_word = sel_word | req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          shreg_d = sel_word;
          owner_d = grant_idx;
          last_d  = grant_idx;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointer resets to NREQ-1 so requester 0 is searched first after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // All status outputs are decoded from registers only.
  assign shift_en    = (state_q == ST_SHIFT);
  assign serial_out  = shift_en && shreg_q[WIDTH-1];
  assign frame_start = shift_en && (cnt_q == '0);
  assign busy        = (state_q != ST_IDLE);
  assign owner       = owner_q;

endmodule

// File: tb/tb_serial_shift_scheduler.sv
module tb_serial_shift_scheduler;

  localparam int W = 8;
  localparam int N = 4;
  localparam int G = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic           serial_out, shift_en, frame_start, busy;
  logic [1:0]     owner;

  logic [N-1:0]   req_valid_g0, req_ready_g0;
  logic [N*W-1:0] req_data_g0;
  logic           serial_out_g0, shift_en_g0, frame_start_g0, busy_g0;
  logic [1:0]     owner_g0;

  int checks   = 0;
  int failures = 0;

  serial_shift_scheduler #(.WIDTH(W), .NREQ(N), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .serial_out(serial_out), .shift_en(shift_en),
    .frame_start(frame_start), .owner(owner), .busy(busy)
  );

  serial_shift_scheduler #(.WIDTH(W), .NREQ(N), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .reset(reset), .req_valid(req_valid_g0), .req_data(req_data_g0),
    .req_ready(req_ready_g0), .serial_out(serial_out_g0), .shift_en(shift_en_g0),
    .frame_start(frame_start_g0), .owner(owner_g0), .busy(busy_g0)
  );

  typedef struct {
    logic sb;
    logic se;
    logic fs;
    logic bz;
    int   own;
  } exp_t;

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0;
    req_valid_g0 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = '1;
    req_valid_g0 = '1;
    req_data = $urandom;
    req_data_g0 = $urandom;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({serial_out, shift_en, frame_start, busy} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_outputs got=%b exp=0000", {serial_out, shift_en, frame_start, busy});
      end
      checks++;
      if (req_ready !== 4'b0000 || req_ready_g0 !== 4'b0000) begin
        failures++;
        $display("FAIL reset_ready got=%b/%b exp=0000", req_ready, req_ready_g0);
      end
      checks++;
      if (owner !== 2'd0 || busy_g0 !== 1'b0) begin
        failures++;
        $display("FAIL reset_owner owner=%0d busy_g0=%b exp=0/0", owner, busy_g0);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    req_valid_g0 = '0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    w = 8'hA5;
    req_valid = 4'b0100;
    req_data = $urandom;
    req_data[2*W +: W] = w;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_grant got=%b exp=0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    req_data = $urandom;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      checks++;
      if (serial_out !== w[W-1-k] || shift_en !== 1'b1 || frame_start !== (k == 0)
          || owner !== 2'd2 || busy !== 1'b1) begin
        failures++;
        $display("FAIL single_bit[%0d] got so=%b se=%b fs=%b own=%0d bz=%b exp so=%b se=1 fs=%b own=2 bz=1",
                 k, serial_out, shift_en, frame_start, owner, busy, w[W-1-k], (k == 0));
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || shift_en !== 1'b0 || serial_out !== 1'b0) begin
      failures++;
      $display("FAIL single_gap got bz=%b se=%b so=%b exp 1/0/0", busy, shift_en, serial_out);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got bz=%b exp=0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int grants[$];
    int gcyc[$];
    int bitpos;
    int idx;
    logic [W-1:0] cur;
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'h11 * (i + 1)) ^ W'($urandom_range(0, 255));
    bitpos = -1;
    cur = '0;
    for (int cyc = 0; cyc < 52; cyc++) begin
      @(negedge clk);
      if (bitpos >= 0) begin
        checks++;
        if (serial_out !== cur[W-1-bitpos]) begin
          failures++;
          $display("FAIL rr_bit[%0d] cyc=%0d got=%b exp=%b", bitpos, cyc, serial_out, cur[W-1-bitpos]);
        end
        bitpos++;
        if (bitpos == W) bitpos = -1;
      end
      if (req_ready != '0) begin
        checks++;
        if (!$onehot(req_ready)) begin
          failures++;
          $display("FAIL rr_onehot got=%b", req_ready);
        end
        idx = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
        grants.push_back(idx);
        gcyc.push_back(cyc);
        cur = req_data[idx*W +: W];
        bitpos = 0;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    checks++;
    if (grants.size() < 5) begin
      failures++;
      $display("FAIL rr_count got=%0d exp>=5", grants.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grants[i] != i % N) begin
          failures++;
          $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, grants[i], i % N);
        end
        if (i > 0) begin
          checks++;
          if (gcyc[i] - gcyc[i-1] != W + G + 1) begin
            failures++;
            $display("FAIL rr_period[%0d] got=%0d exp=%0d", i, gcyc[i] - gcyc[i-1], W + G + 1);
          end
        end
      end
    end
  endtask

  task automatic test_late_arrival();
    do_reset();
    req_valid = 4'b1000;
    req_data = $urandom;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL late_first got=%b exp=1000", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    for (int c = 1; c <= W + G; c++) begin
      if (c == 3) req_valid = 4'b0010;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL late_wait[%0d] got=%b exp=0000", c, req_ready);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010 || busy !== 1'b0) begin
      failures++;
      $display("FAIL late_grant got=%b bz=%b exp=0010 bz=0", req_ready, busy);
    end
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic test_request_drop();
    do_reset();
    req_valid = 4'b0100;
    req_data = $urandom;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL drop_first got=%b exp=0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 2) req_valid = 4'b0001;
      if (c == 3) req_valid = 4'b0000;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL drop_ready[%0d] got=%b exp=0000", c, req_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    req_valid = '1;
    req_data = $urandom;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_first got=%b exp=0001", req_ready);
    end
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++;
    if (shift_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_active got se=%b bz=%b exp 1/1", shift_en, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({serial_out, shift_en, frame_start, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_abort got=%b exp=0000", {serial_out, shift_en, frame_start, busy});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_restart got=%b exp=0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic test_gap0();
    int fs[$];
    logic [N-1:0] grants[$];
    logic se[40];
    logic so[40];
    int lows;
    logic [W-1:0] w0;
    do_reset();
    req_valid_g0 = 4'b0011;
    req_data_g0 = $urandom;
    w0 = req_data_g0[W-1:0];
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      se[c] = shift_en_g0;
      so[c] = serial_out_g0;
      if (frame_start_g0 === 1'b1) fs.push_back(c);
      if (req_ready_g0 != '0) grants.push_back(req_ready_g0);
      @(posedge clk); #1;
    end
    req_valid_g0 = '0;
    checks++;
    if (fs.size() < 2 || grants.size() < 2) begin
      failures++;
      $display("FAIL gap0_frames got fs=%0d grants=%0d exp>=2", fs.size(), grants.size());
    end else begin
      checks++;
      if (fs[1] - fs[0] != W + 1) begin
        failures++;
        $display("FAIL gap0_spacing got=%0d exp=%0d", fs[1] - fs[0], W + 1);
      end
      lows = 0;
      for (int c = fs[0] + 1; c < fs[1] && c < 40; c++) if (se[c] !== 1'b1) lows++;
      checks++;
      if (lows != 1) begin
        failures++;
        $display("FAIL gap0_low got=%0d exp=1", lows);
      end
      checks++;
      if (grants[0] !== 4'b0001 || grants[1] !== 4'b0010) begin
        failures++;
        $display("FAIL gap0_order got=%b,%b exp=0001,0010", grants[0], grants[1]);
      end
      for (int k = 0; k < W; k++) begin
        checks++;
        if (fs[0] + k < 40 && so[fs[0] + k] !== w0[W-1-k]) begin
          failures++;
          $display("FAIL gap0_bit[%0d] got=%b exp=%b", k, so[fs[0] + k], w0[W-1-k]);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t mq[$];
    exp_t e;
    logic idle_now;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] w;
    int m_last;
    int cand;
    do_reset();
    m_last = N - 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req_valid = '0;
      req_data = $urandom;
      @(negedge clk);
      if (mq.size() > 0) begin
        e = mq.pop_front();
        idle_now = 1'b0;
      end else begin
        e = '{sb: 1'b0, se: 1'b0, fs: 1'b0, bz: 1'b0, own: 0};
        idle_now = 1'b1;
      end
      checks++;
      if ({serial_out, shift_en, frame_start, busy} !== {e.sb, e.se, e.fs, e.bz}) begin
        failures++;
        $display("FAIL rand_out cyc=%0d got=%b exp=%b", cyc,
                 {serial_out, shift_en, frame_start, busy}, {e.sb, e.se, e.fs, e.bz});
      end
      if (e.se) begin
        checks++;
        if (owner !== 2'(e.own)) begin
          failures++;
          $display("FAIL rand_owner cyc=%0d got=%0d exp=%0d", cyc, owner, e.own);
        end
      end
      exp_rdy = '0;
      if (idle_now) begin
        for (int k = 1; k <= N; k++) begin
          cand = (m_last + k) % N;
          if (exp_rdy == '0 && req_valid[cand]) exp_rdy[cand] = 1'b1;
        end
      end
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
      end
      if (exp_rdy != '0) begin
        for (int i = 0; i < N; i++) if (exp_rdy[i]) m_last = i;
        w = req_data[m_last*W +: W];
        for (int k = 0; k < W; k++)
          mq.push_back('{sb: w[W-1-k], se: 1'b1, fs: (k == 0), bz: 1'b1, own: m_last});
        for (int k = 0; k < G; k++)
          mq.push_back('{sb: 1'b0, se: 1'b0, fs: 1'b0, bz: 1'b1, own: m_last});
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_valid_g0 = '0;
    req_data_g0 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_late_arrival();
    test_request_drop();
    test_reset_mid_frame();
    test_gap0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
